io_bank_fabric: RTL and testbench
=================================

Name: io_bank_fabric

Overview:
- Parametrised successor to the fixed address decoder / read-data mux in the nano6502 top level.
- Decodes the 6502 map into RAM, ROM overlay and a banked IO page. Supports up to NUM_BANKS IO slaves.
- Muxes read data back to the CPU.
- Adds per-bank interrupt latching, masking and priority encoding so the CPU IRQ input no longer has to be tied off.

Parameters:
- NUM_BANKS, 16, number of IO bank slots (2..256); bank 0 is always the ROM view of the IO page
- IO_PAGE, 8'hFE, high address byte of the banked IO page
- VEC_PAGE, 8'hFF, high address byte of the always-ROM vector page
- ROM_LO, 8'hE0, first high address byte of the switchable ROM window (window is ROM_LO..IO_PAGE-1)

Ports:
- clk_i, in, 1, system clock
- rst_n_i, in, 1, asynchronous active-low reset
- R_W_n, in, 1, registered CPU read/write (1 = read)
- addr_i, in, 16, live CPU address (read decode)
- addr_w_i, in, 16, CPU address registered one cycle (write decode)
- data_i, in, 8, CPU write data
- ram_data_i, in, 8, RAM read data
- rom_data_i, in, 8, ROM read data
- slave_data_i, in, 8*NUM_BANKS, packed slave read data; bank n at [8n+7:8n]
- irq_i, in, NUM_BANKS, level interrupt requests from slaves (bit 0 unused, tie 0)
- data_o, out, 8, read data to CPU
- ram_cs, out, 1, RAM select
- ram_we, out, 1, RAM write enable
- rom_cs, out, 1, ROM select
- bank_cs, out, NUM_BANKS, one-hot IO slave select
- irq_o, out, 1, active-high IRQ to CPU (registered)

Behaviour:
- Fabric registers at 0x0000-0x0007; these shadow RAM and are never written to RAM:
  - 0 bank_l, 1 bank_h, 2 rom_off (bit0), 3 mask_l, 4 mask_h, 5 pend_l, 6 pend_h.
  - 7 irq_id: read-only; index of lowest set bit of pend&mask, or 0xFF if none.
- Reset values: all registers 0 (bank 0, ROM mapped, all masked, none pending); irq_o=0.
- Combinational outputs follow the reset register state.
- Decode address: addr_i when R_W_n=1, else addr_w_i.
- Decode priority:
  - 0x0000-0x0007 → fabric.
  - VEC_PAGE → rom_cs.
  - IO_PAGE → bank {bank_h,bank_l}:
    - Bank 0 → rom_cs.
    - Bank 1..NUM_BANKS-1 → that bank_cs bit.
    - Bank ≥ NUM_BANKS → no cs; reads return 0xFF; writes are dropped.
  - ROM window → rom_cs if rom_off=0 and read, else ram_cs.
  - Everything else → ram_cs.
- Writes to the ROM window always reach RAM (ram_we=1), whatever rom_off is.
- Writes to VEC_PAGE are dropped.
- At most one cs asserted at a time; bank_cs is one-hot or zero.
- ram_we = ram_cs & ~R_W_n.
- data_o is combinational from the selected source with zero added latency. With no source selected, data_o = data_i.
- Register writes: at a posedge with R_W_n=0, using addr_w_i. The new value is visible to reads from the next cycle.
- Interrupts:
  - irq_prev <= irq_i every cycle; pend[n] sets on irq_i[n] & ~irq_prev[n] (rising edge).
  - Writing 1 to a pend bit clears it. If set and clear coincide in the same cycle, set wins.
  - pend bits ≥ NUM_BANKS and bit 0 read as 0.
  - irq_o <= |(pend & mask), registered; one cycle after the pend/mask change.
- Reset mid-access: all state clears at once, asynchronously; the first cycle after release decodes with bank 0 and ROM mapped.

Decomposition:
- Package io_fabric_pkg holds:
  - Register offset constants REG_BANK_L..REG_IRQ_ID.
  - Default page constants.
  - IRQ_NONE = 8'hFF.
- Sub-module irq_ctrl (edge detect, pending, mask, priority encoder, irq_o register), parametrised by NUM_BANKS. Decode and mux stay in io_bank_fabric.

Test Plan:
- Reset, then read 0xE000 and 0xFE00 → rom_cs=1 for both, data_o=rom_data_i; read 0x0000 → 0x00.
- Write 0x05 to 0x0000, then read 0xFE10 → bank_cs=16'h0020, data_o=slave_data_i[47:40]. Write 0x20 (bank ≥ 16), then read 0xFE00 → no cs, data_o=0xFF.
- Write 0x01 to 0x0002, then read 0xE123 → ram_cs=1. Write 0xAA to 0xF000 with rom_off=0 → ram_we=1. Write to 0xFF00 → ram_we=0, no cs.
- Set mask_l=0x08, pulse irq_i[3] → pend_l=0x08 next cycle, irq_o=1 one cycle later, irq_id=0x03. Write 0x08 to 0x0005 → irq_o=0 two cycles later.
- Rising edge on irq_i[3] in the same cycle as a W1C write to pend bit 3 → bit stays 1. Hold irq_i[3] high → no re-set after a later clear.
- Assert rst_n_i mid-write to 0x0000 → bank_l=0, irq_o=0 immediately; after release, read 0xFE00 → rom_cs=1.

Source files
------------

// File: rtl/io_fabric_pkg.sv
// Shared constants and types for the nano6502 IO bank fabric:
// register map, default page placement and the decode-target enum.
package io_fabric_pkg;

   localparam logic [2:0] REG_BANK_L  = 3'd0;
   localparam logic [2:0] REG_BANK_H  = 3'd1;
   localparam logic [2:0] REG_ROM_OFF = 3'd2;
   localparam logic [2:0] REG_MASK_L  = 3'd3;
   localparam logic [2:0] REG_MASK_H  = 3'd4;
   localparam logic [2:0] REG_PEND_L  = 3'd5;
   localparam logic [2:0] REG_PEND_H  = 3'd6;
   localparam logic [2:0] REG_IRQ_ID  = 3'd7;

   localparam logic [7:0] DEF_IO_PAGE  = 8'hFE;
   localparam logic [7:0] DEF_VEC_PAGE = 8'hFF;
   localparam logic [7:0] DEF_ROM_LO   = 8'hE0;

   localparam logic [7:0] IRQ_NONE = 8'hFF;

   // Pending/mask registers are two bytes wide, so at most 16 interrupt sources.
   localparam int unsigned IRQ_W = 16;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_FABRIC,
      SEL_RAM,
      SEL_ROM,
      SEL_BANK,
      SEL_VOID
   } sel_e;

endpackage

// File: rtl/io_bank_fabric_irq.sv
// Interrupt controller: rising-edge detect, W1C pending bits, mask,
// lowest-index priority encoder and the registered CPU IRQ line.
module irq_ctrl
   import io_fabric_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_BANKS-1:0] i_irq,
   input  logic                 i_wr_en,
   input  logic [2:0]           i_wr_addr,
   input  logic [7:0]           i_wr_data,
   output logic [IRQ_W-1:0]     o_mask,
   output logic [IRQ_W-1:0]     o_pend,
   output logic [7:0]           o_irq_id,
   output logic                 o_irq
);

   logic [IRQ_W-1:0] r_mask;
   logic [IRQ_W-1:0] r_pend;
   logic [IRQ_W-1:0] r_prev;
   logic             r_irq;
   logic [IRQ_W-1:0] w_irq;
   logic [IRQ_W-1:0] w_valid;
   logic [IRQ_W-1:0] w_set;
   logic [IRQ_W-1:0] w_clr;
   logic [IRQ_W-1:0] w_active;

   // Bit 0 is the ROM slot and never raises an interrupt.
   always_comb begin
      w_irq   = '0;
      w_valid = '0;
      for (int unsigned n = 0; n < IRQ_W; n++) begin
         if (n < NUM_BANKS) begin
            w_irq[n]   = i_irq[n];
            w_valid[n] = (n != 0);
         end
      end
   end

   always_comb begin
      w_clr = '0;
      if (i_wr_en && i_wr_addr == REG_PEND_L) w_clr = {8'h00, i_wr_data};
      if (i_wr_en && i_wr_addr == REG_PEND_H) w_clr = {i_wr_data, 8'h00};
   end

   assign w_set    = w_irq & ~r_prev & w_valid;
   assign w_active = r_pend & r_mask;

   always_comb begin
      o_irq_id = IRQ_NONE;
      for (int unsigned n = 0; n < IRQ_W; n++) begin
         if (w_active[n] && o_irq_id == IRQ_NONE) o_irq_id = 8'(n);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mask <= '0;
         r_pend <= '0;
         r_prev <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_prev <= w_irq;
         r_pend <= (r_pend & ~w_clr) | w_set;
         r_irq  <= |w_active;
         if (i_wr_en && i_wr_addr == REG_MASK_L) r_mask[7:0]  <= i_wr_data;
         if (i_wr_en && i_wr_addr == REG_MASK_H) r_mask[15:8] <= i_wr_data;
      end
   end

   assign o_mask = r_mask;
   assign o_pend = r_pend;
   assign o_irq  = r_irq;

endmodule

// File: rtl/io_bank_fabric.sv
// 6502 address decoder and read-data mux: RAM, switchable ROM window,
// always-ROM vector page and a banked IO page, plus fabric registers at 0x0000.
module io_bank_fabric
   import io_fabric_pkg::*;
#(
   parameter int unsigned NUM_BANKS = 16,
   parameter logic [7:0]  IO_PAGE   = DEF_IO_PAGE,
   parameter logic [7:0]  VEC_PAGE  = DEF_VEC_PAGE,
   parameter logic [7:0]  ROM_LO    = DEF_ROM_LO
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   R_W_n,
   input  logic [15:0]            addr_i,
   input  logic [15:0]            addr_w_i,
   input  logic [7:0]             data_i,
   input  logic [7:0]             ram_data_i,
   input  logic [7:0]             rom_data_i,
   input  logic [8*NUM_BANKS-1:0] slave_data_i,
   input  logic [NUM_BANKS-1:0]   irq_i,
   output logic [7:0]             data_o,
   output logic                   ram_cs,
   output logic                   ram_we,
   output logic                   rom_cs,
   output logic [NUM_BANKS-1:0]   bank_cs,
   output logic                   irq_o
);

   logic [7:0]       r_bank_l;
   logic [7:0]       r_bank_h;
   logic             r_rom_off;
   logic [15:0]      w_bank;
   logic [15:0]      w_addr;
   logic [7:0]       w_hi;
   sel_e             w_sel;
   logic             w_fab_we;
   logic [7:0]       w_reg_rd;
   logic [7:0]       w_slave;
   logic [IRQ_W-1:0] w_mask;
   logic [IRQ_W-1:0] w_pend;
   logic [7:0]       w_irq_id;

   assign w_bank   = {r_bank_h, r_bank_l};
   assign w_addr   = R_W_n ? addr_i : addr_w_i;
   assign w_hi     = w_addr[15:8];
   assign w_fab_we = ~R_W_n & (addr_w_i[15:3] == '0);

   always_comb begin
      w_sel = SEL_RAM;
      if (w_addr[15:3] == '0) begin
         w_sel = SEL_FABRIC;
      end else if (w_hi == VEC_PAGE) begin
         w_sel = R_W_n ? SEL_ROM : SEL_NONE;
      end else if (w_hi == IO_PAGE) begin
         if (w_bank == '0)                    w_sel = SEL_ROM;
         else if (w_bank < 16'(NUM_BANKS))    w_sel = SEL_BANK;
         else                                 w_sel = SEL_VOID;
      end else if (w_hi >= ROM_LO && w_hi < IO_PAGE) begin
         // The window is read-only ROM; writes fall through to the RAM beneath.
         w_sel = (R_W_n && !r_rom_off) ? SEL_ROM : SEL_RAM;
      end
   end

   always_comb begin
      bank_cs = '0;
      w_slave = 8'hFF;
      for (int unsigned n = 0; n < NUM_BANKS; n++) begin
         if (w_sel == SEL_BANK && w_bank == 16'(n)) begin
            bank_cs[n] = 1'b1;
            w_slave    = slave_data_i[8*n +: 8];
         end
      end
   end

   assign ram_cs = (w_sel == SEL_RAM);
   assign rom_cs = (w_sel == SEL_ROM);
   assign ram_we = ram_cs & ~R_W_n;

   always_comb begin
      case (w_addr[2:0])
         REG_BANK_L:  w_reg_rd = r_bank_l;
         REG_BANK_H:  w_reg_rd = r_bank_h;
         REG_ROM_OFF: w_reg_rd = {7'b0, r_rom_off};
         REG_MASK_L:  w_reg_rd = w_mask[7:0];
         REG_MASK_H:  w_reg_rd = w_mask[15:8];
         REG_PEND_L:  w_reg_rd = w_pend[7:0];
         REG_PEND_H:  w_reg_rd = w_pend[15:8];
         REG_IRQ_ID:  w_reg_rd = w_irq_id;
         default:     w_reg_rd = 8'hFF;
      endcase
   end

   always_comb begin
      case (w_sel)
         SEL_FABRIC: data_o = R_W_n ? w_reg_rd : data_i;
         SEL_RAM:    data_o = ram_data_i;
         SEL_ROM:    data_o = rom_data_i;
         SEL_BANK:   data_o = w_slave;
         SEL_VOID:   data_o = R_W_n ? 8'hFF : data_i;
         default:    data_o = data_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_bank_l  <= '0;
         r_bank_h  <= '0;
         r_rom_off <= 1'b0;
      end else if (w_fab_we) begin
         if (addr_w_i[2:0] == REG_BANK_L)  r_bank_l  <= data_i;
         if (addr_w_i[2:0] == REG_BANK_H)  r_bank_h  <= data_i;
         if (addr_w_i[2:0] == REG_ROM_OFF) r_rom_off <= data_i[0];
      end
   end

   irq_ctrl #(
      .NUM_BANKS (NUM_BANKS)
   ) u_irq (
      .i_clk     (clk_i),
      .i_rst_n   (rst_n_i),
      .i_irq     (irq_i),
      .i_wr_en   (w_fab_we),
      .i_wr_addr (addr_w_i[2:0]),
      .i_wr_data (data_i),
      .o_mask    (w_mask),
      .o_pend    (w_pend),
      .o_irq_id  (w_irq_id),
      .o_irq     (irq_o)
   );

endmodule

// File: tb/tb_io_bank_fabric.sv
// Bench for io_bank_fabric: directed walk through the memory map and
// interrupt behaviour, then randomized traffic against a behavioural model.
module tb_io_bank_fabric;

   localparam int NB = 16;

   logic            clk_i = 1'b0;
   logic            rst_n_i;
   logic            R_W_n;
   logic [15:0]     addr_i, addr_w_i;
   logic [7:0]      data_i, ram_data_i, rom_data_i;
   logic [8*NB-1:0] slave_data_i;
   logic [NB-1:0]   irq_i;
   logic [7:0]      data_o;
   logic            ram_cs, ram_we, rom_cs, irq_o;
   logic [NB-1:0]   bank_cs;

   int n_checks = 0;
   int n_errors = 0;

   // reference state
   logic [15:0] m_bank;
   bit          m_rom_off;
   logic [15:0] m_mask, m_pend, m_prev;
   bit          m_irq_o;

   // predicted combinational outputs
   bit          e_ram, e_we, e_rom;
   logic [15:0] e_bank;
   logic [7:0]  e_data;

   // samples from the last cycle
   logic [7:0]  s_data;
   logic [15:0] s_bank_cs;
   logic        s_ram_cs, s_ram_we, s_rom_cs, s_irq, s_irq_post;

   io_bank_fabric #(
      .NUM_BANKS (NB),
      .IO_PAGE   (8'hFE),
      .VEC_PAGE  (8'hFF),
      .ROM_LO    (8'hE0)
   ) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .R_W_n        (R_W_n),
      .addr_i       (addr_i),
      .addr_w_i     (addr_w_i),
      .data_i       (data_i),
      .ram_data_i   (ram_data_i),
      .rom_data_i   (rom_data_i),
      .slave_data_i (slave_data_i),
      .irq_i        (irq_i),
      .data_o       (data_o),
      .ram_cs       (ram_cs),
      .ram_we       (ram_we),
      .rom_cs       (rom_cs),
      .bank_cs      (bank_cs),
      .irq_o        (irq_o)
   );

   initial forever #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bank = '0; m_rom_off = 0; m_mask = '0; m_pend = '0; m_prev = '0; m_irq_o = 0;
   endtask

   function automatic logic [7:0] model_irq_id();
      logic [15:0] act;
      act = m_pend & m_mask;
      for (int i = 0; i < 16; i++) if (act[i]) return 8'(i);
      return 8'hFF;
   endfunction

   function automatic logic [7:0] model_reg(input int off);
      case (off)
         0: return m_bank[7:0];
         1: return m_bank[15:8];
         2: return {7'b0, m_rom_off};
         3: return m_mask[7:0];
         4: return m_mask[15:8];
         5: return m_pend[7:0];
         6: return m_pend[15:8];
         default: return model_irq_id();
      endcase
   endfunction

   task automatic predict();
      logic [15:0] a;
      int          hi;
      a = R_W_n ? addr_i : addr_w_i;
      hi = int'(a[15:8]);
      e_ram = 0; e_rom = 0; e_bank = '0; e_data = data_i;
      if (a < 16'd8) begin
         if (R_W_n) e_data = model_reg(int'(a));
      end else if (hi == 'hFF) begin
         if (R_W_n) begin e_rom = 1; e_data = rom_data_i; end
      end else if (hi == 'hFE) begin
         if (m_bank == 0) begin
            e_rom = 1; e_data = rom_data_i;
         end else if (m_bank < NB) begin
            e_bank = 16'(1) << m_bank;
            e_data = slave_data_i[8*int'(m_bank) +: 8];
         end else begin
            e_data = 8'hFF;
         end
      end else if (hi >= 'hE0 && R_W_n && !m_rom_off) begin
         e_rom = 1; e_data = rom_data_i;
      end else begin
         e_ram = 1; e_data = ram_data_i;
      end
      e_we = e_ram && !R_W_n;
   endtask

   // Advance the model across one rising edge using the currently driven inputs.
   task automatic model_step();
      logic [15:0] clr, set;
      bit          nxt_irq;
      clr = '0; set = '0;
      nxt_irq = |(m_pend & m_mask);
      if (!R_W_n && addr_w_i < 16'd8) begin
         case (int'(addr_w_i))
            0: m_bank[7:0]  = data_i;
            1: m_bank[15:8] = data_i;
            2: m_rom_off    = data_i[0];
            3: m_mask[7:0]  = data_i;
            4: m_mask[15:8] = data_i;
            5: clr[7:0]     = data_i;
            6: clr[15:8]    = data_i;
            default: ;
         endcase
      end
      for (int n = 1; n < NB; n++) if (irq_i[n] && !m_prev[n]) set[n] = 1'b1;
      m_pend  = (m_pend & ~clr) | set;
      m_prev  = irq_i;
      m_irq_o = nxt_irq;
   endtask

   task automatic cyc(input bit rw, input logic [15:0] a, input logic [7:0] d, input logic [15:0] irq);
      @(negedge clk_i);
      R_W_n = rw;
      if (rw) begin addr_i = a; addr_w_i = 16'($urandom); end
      else    begin addr_w_i = a; addr_i = 16'($urandom); end
      data_i = d; irq_i = irq;
      ram_data_i = 8'($urandom); rom_data_i = 8'($urandom);
      for (int b = 0; b < NB; b++) slave_data_i[8*b +: 8] = 8'($urandom);
      #2;
      predict();
      s_data = data_o; s_bank_cs = bank_cs; s_ram_cs = ram_cs;
      s_ram_we = ram_we; s_rom_cs = rom_cs; s_irq = irq_o;
      check("ram_cs", ram_cs, e_ram);
      check("ram_we", ram_we, e_we);
      check("rom_cs", rom_cs, e_rom);
      check("bank_cs", bank_cs, e_bank);
      if (rw) check("data_o", data_o, e_data);
      check("irq_o", irq_o, m_irq_o);
      @(posedge clk_i);
      model_step();
      #1;
      s_irq_post = irq_o;
      check("irq_o_edge", irq_o, m_irq_o);
   endtask

   initial begin
      logic [15:0] irq_r, a;
      logic [7:0]  d;
      bit          rw;

      rst_n_i = 0; R_W_n = 1; addr_i = 16'h0000; addr_w_i = '0; data_i = 8'h5A;
      ram_data_i = 8'h11; rom_data_i = 8'h22; slave_data_i = '0; irq_i = '0;
      model_reset();
      #3;
      check("rst_irq_o", irq_o, 0);
      check("rst_bank_l", data_o, 8'h00);
      @(negedge clk_i); rst_n_i = 1;
      @(posedge clk_i); model_step();

      // map after reset
      cyc(1, 16'hE000, 8'h00, 16'h0);
      check("tp_rom_win", s_rom_cs, 1);
      cyc(1, 16'hFE00, 8'h00, 16'h0);
      check("tp_io_bank0", s_rom_cs, 1);
      cyc(1, 16'h0000, 8'h00, 16'h0);
      check("tp_bank_l_rst", s_data, 8'h00);

      // bank switching
      cyc(0, 16'h0000, 8'h05, 16'h0);
      cyc(1, 16'hFE10, 8'h00, 16'h0);
      check("tp_bank5_cs", s_bank_cs, 16'h0020);
      check("tp_bank5_data", s_data, slave_data_i[47:40]);
      cyc(0, 16'h0000, 8'h20, 16'h0);
      cyc(1, 16'hFE00, 8'h00, 16'h0);
      check("tp_void_cs", {s_bank_cs, s_rom_cs, s_ram_cs}, 0);
      check("tp_void_data", s_data, 8'hFF);
      cyc(0, 16'h0000, 8'h00, 16'h0);

      // ROM window / vector page
      cyc(0, 16'h0002, 8'h01, 16'h0);
      cyc(1, 16'hE123, 8'h00, 16'h0);
      check("tp_romoff_ram", s_ram_cs, 1);
      cyc(0, 16'h0002, 8'h00, 16'h0);
      cyc(0, 16'hF000, 8'hAA, 16'h0);
      check("tp_win_we", s_ram_we, 1);
      cyc(0, 16'hFF00, 8'h33, 16'h0);
      check("tp_vec_we", s_ram_we, 0);
      check("tp_vec_cs", {s_bank_cs, s_rom_cs, s_ram_cs}, 0);

      // interrupt path
      cyc(0, 16'h0003, 8'h08, 16'h0);
      cyc(1, 16'h0005, 8'h00, 16'h0008);
      cyc(1, 16'h0005, 8'h00, 16'h0000);
      check("tp_pend_l", s_data, 8'h08);
      check("tp_irq_lag", s_irq, 0);
      check("tp_irq_set", s_irq_post, 1);
      cyc(1, 16'h0007, 8'h00, 16'h0);
      check("tp_irq_id", s_data, 8'h03);
      cyc(0, 16'h0005, 8'h08, 16'h0);
      check("tp_clr_lag", s_irq_post, 1);
      cyc(1, 16'h0000, 8'h00, 16'h0);
      check("tp_clr_irq", s_irq_post, 0);

      // set beats clear; held level does not re-set
      cyc(0, 16'h0005, 8'h08, 16'h0008);
      cyc(1, 16'h0005, 8'h00, 16'h0008);
      check("tp_set_wins", s_data, 8'h08);
      cyc(0, 16'h0005, 8'h08, 16'h0008);
      cyc(1, 16'h0005, 8'h00, 16'h0008);
      check("tp_level_noset", s_data, 8'h00);

      // asynchronous reset mid-write
      cyc(0, 16'h0000, 8'h05, 16'h0008);
      cyc(1, 16'h0100, 8'h00, 16'h0000);
      cyc(1, 16'h0100, 8'h00, 16'h0008);
      cyc(1, 16'h0100, 8'h00, 16'h0008);
      check("tp_pre_rst_irq", s_irq_post, 1);
      @(negedge clk_i);
      R_W_n = 0; addr_w_i = 16'h0000; data_i = 8'h07; irq_i = '0;
      #2 rst_n_i = 0; model_reset();
      #1 check("tp_rst_irq", irq_o, 0);
      R_W_n = 1; addr_i = 16'hFE10;
      #1 check("tp_rst_rom", rom_cs, 1);
      check("tp_rst_bank", bank_cs, 16'h0);
      addr_i = 16'h0000;
      #1 check("tp_rst_bank_l", data_o, 8'h00);
      @(negedge clk_i); rst_n_i = 1; addr_i = 16'hFE00;
      #2 check("tp_rel_rom", rom_cs, 1);
      @(posedge clk_i); model_step();
      cyc(1, 16'hFE00, 8'h00, 16'h0);
      check("tp_rel_rom2", s_rom_cs, 1);

      // randomized traffic
      irq_r = '0;
      for (int i = 0; i < 600; i++) begin
         rw = $urandom_range(0, 2) != 0;
         case ($urandom_range(0, 5))
            0: a = 16'($urandom_range(0, 7));
            1: a = {8'hFF, 8'($urandom)};
            2: a = {8'hFE, 8'($urandom)};
            3: a = {8'($urandom_range(8'hE0, 8'hFD)), 8'($urandom)};
            4: a = 16'($urandom);
            default: a = 16'($urandom_range(8, 255));
         endcase
         d = 8'($urandom);
         if (!rw && a == 16'd0) d = 8'($urandom_range(0, 20));
         if (!rw && a == 16'd1) d = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
         irq_r = irq_r ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
         cyc(rw, a, d, irq_r);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
